// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding, step modes and the most-negative helper.
package muldiv_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Iteration kind selected in the shared step datapath
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // Most-negative two's-complement value for a given width (valid up to 64 bits)
  function automatic logic [63:0] most_neg(input int width);
    most_neg = 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration shared by multiply and divide.
// Multiply: acc = {partial_hi, multiplier}; add operand when acc[0], shift right.
// Divide:   acc = {remainder, quotient}; shift left, trial subtract, keep if >= 0.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_ext;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] div_rem;

  // Compute both step flavours and pick one; the unused half is cheap logic.
  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Remainder after the left shift can need WIDTH+1 bits before the subtract.
    rem_ext = acc_i[2*WIDTH-1:WIDTH-1];
    div_ge  = (rem_ext >= {1'b0, operand_i});
    // When the subtract is kept the difference is below the divisor, so WIDTH bits suffice.
    div_sub = rem_ext[WIDTH-1:0] - operand_i;
    div_rem = div_ge ? div_sub : rem_ext[WIDTH-1:0];
    if (mode_i == MODE_DIV) begin
      acc_o = {div_rem, acc_i[WIDTH-2:0], div_ge};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Operands are reduced to magnitudes at accept, WIDTH single-bit iterations run in
// CALC, and FIX applies sign correction and word selection before DONE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use one combinational multiplier
// and skip CALC; divides remain iterative.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  logic [1:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0]   opnd_q,    opnd_d;
  logic [2:0]         op_q,      op_d;
  logic               neg_q,     neg_d;      // product / quotient needs negation
  logic               neg_rem_q, neg_rem_d;  // remainder needs negation (dividend negative)
  logic [WIDTH-1:0]   result_q,  result_d;

  // Accept-time operand decode
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   special_val;

  // Finishing datapath
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_val;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i    (op_q[2]),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc)
  );

  // Decode signedness of the incoming op and build magnitudes and special results.
  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    a_mag    = a_neg ? (-a) : a;
    b_mag    = b_neg ? (-b) : b;
    div_zero = op[2] && (b == '0);
    // Only the signed divide ops (funct3[0] clear) can overflow.
    div_ovf  = op[2] && !op[0] && (a == MOST_NEG) && (b == '1);
    if (div_zero) begin
      special_val = op[1] ? a : '1;
    end else begin
      special_val = op[1] ? '0 : a;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product of magnitudes; sign handling is shared with the iterative path.
  always_comb begin
    fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  end
`endif

  // Sign correction and word selection applied in FIX.
  always_comb begin
    prod_fix = neg_q ? (-acc_q) : acc_q;
    quo_fix  = neg_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    if (op_q[2]) begin
      fix_val = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q == OP_MUL) begin
      fix_val = prod_fix[WIDTH-1:0];
    end else begin
      fix_val = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic for the controller and datapath registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d      = op;
          // MUL keeps both signs clear, so its low word comes out of the unsigned product.
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_zero || div_ovf) begin
            result_d = special_val;
            state_d  = ST_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!op[2]) begin
            acc_d   = fast_prod;
            state_d = ST_FIX;
          end
`endif
          else begin
            // Divide: dividend in the low half; multiply: multiplier in the low half.
            acc_d   = op[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd_d  = op[2] ? b_mag : a_mag;
            cnt_d   = CNT_W'(WIDTH);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fix_val;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide unit, parametrised in WIDTH.
- Sits beside the single-cycle ALU in the execute stage. Takes the same rs1/rs2 operands plus funct3.
- Uses a valid/ready handshake on input and output, so the core can stall while busy.
- Produces one result bit per cycle: shift-add multiply, restoring divide.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 4 and even.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  unit can accept an operation; high only in IDLE.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  operand rs1.
- b  in  WIDTH  operand rs2.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  product or quotient/remainder word selected by op.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0, internal registers=0.
- Reset mid-operation aborts with no output; the next cycle is IDLE.
- Accept: an op is accepted on an edge where in_valid && in_ready. op and a/b are latched.
- Operand conversion at accept:
  - Signed operands are converted to magnitude with the sign remembered.
  - MULHSU: a signed, b unsigned.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: waits for accept.
  - Special divide cases go directly to DONE.
  - All other ops go to CALC with counter = WIDTH.
- CALC, one iteration per cycle; counter decrements and moves to FIX when it reaches 1.
  - Multiply: 2*WIDTH-bit accumulator; conditional add of multiplicand, then right shift.
  - Divide: restoring step on {remainder, quotient}; shift left, trial subtract, keep if non-negative.
- FIX, one cycle:
  - Applies two's-complement negation where the operand signs require it.
  - Selects the low word (MUL) or high word (MULH*), or the quotient/remainder word.
  - Registers result.
- DONE: out_valid=1, and result is held stable until out_ready. On an edge with out_ready, go to IDLE.
  - No new op is accepted in the DONE cycle; in_ready=0.
- Latency:
  - Normal ops: out_valid rises WIDTH+2 edges after the accepting edge.
  - Special cases: out_valid rises 1 edge after the accepting edge.
- Divide by zero (b==0):
  - DIV/DIVU give all-ones.
  - REM/REMU give a unchanged.
- Signed overflow (DIV/REM with a = 1<<(WIDTH-1) and b = all-ones):
  - DIV gives a.
  - REM gives 0.
- Signs:
  - Remainder takes the sign of the dividend.
  - Quotient is negated when the operand signs differ.
  - MUL low word is identical for all signedness.
- Backpressure: out_ready held low keeps DONE indefinitely. in_valid is ignored while busy.
- Simultaneous out_ready and in_valid in DONE: the result is retired and the new op is not taken. It is taken on the next IDLE cycle.
- in_valid with op changing while not ready has no effect.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single combinational WIDTH x WIDTH multiplier.
  - IDLE goes to FIX directly, skipping CALC, so multiply latency is 2 edges.
  - Divide is unchanged.
- Undefined: all multiplies are iterative, WIDTH+2 latency. No multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg holds:
  - op localparams OP_MUL…OP_REMU (3-bit, matching funct3).
  - state encoding ST_IDLE, ST_CALC, ST_FIX, ST_DONE (2-bit).
  - Helper constant for the most-negative value per WIDTH.
- One sub-module, muldiv_step: combinational single iteration.
  - Inputs: mode, accumulator, operand.
  - Output: next accumulator.
  - Reused for the multiply and divide step so CALC stays a thin register stage.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB (-21), out_valid 34 edges after accept (2 with MULDIV_FAST_MUL_EN).
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> 0xFFFFFFFA (-6). REM same -> 0xFFFFFFFE (-2). DIVU a=100, b=7 -> 14. REMU -> 2.
- Divide by zero, DIVU a=0x1234 b=0 -> 0xFFFFFFFF, and REMU -> 0x1234, both out_valid 1 edge after accept. Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0. Then pulse out_ready with in_valid high -> IDLE, the new op is accepted one edge later.
- Assert reset for 1 cycle mid-CALC (counter=16) -> next cycle IDLE, out_valid=0, result=0, in_ready=1. A following DIVU 9/2 -> 4.
